// File: rtl/epu_dma_master.sv
// AXI4 master DMA: copies 32-bit words src->dst in INCR bursts that never cross a 4 KB page.
// Optional cycle counter on cycles_o when EPU_DMA_PERF_CNT_EN is defined (tied to zero otherwise).
module epu_dma_master #(
  parameter int         MAX_BURST = 16,
  parameter logic [3:0] AXI_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] src_i,
  input  logic [31:0] dst_i,
  input  logic [15:0] words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] cycles_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  // states: IDLE | CALC size next burst | AR | R fill buffer | AW | W drain buffer | B | DONE
  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  localparam logic [15:0] MAX_B16 = 16'(MAX_BURST);
  localparam logic [4:0]  MAX_B5  = 5'(MAX_BURST);

  state_t      state_q, state_d;
  logic [31:0] src_q, dst_q;
  logic [15:0] rem_q;
  logic [4:0]  beats_q, idx_q;
  logic        err_q, done_q;
  logic [31:0] buf_q [MAX_BURST];

  logic [15:0] room_src, room_dst, beats_c;
  logic [4:0]  len_m1;
  logic        last_rd, burst_last, berr;

  assign len_m1     = beats_q - 5'd1;
  assign last_rd    = (idx_q == len_m1);
  assign burst_last = (rem_q == {11'd0, beats_q});
  assign berr       = (bresp_i != 2'b00);

  // burst = min(remaining, MAX_BURST, words left in src page, words left in dst page)
  always_comb begin
    room_src = 16'd1024 - {6'd0, src_q[11:2]};
    room_dst = 16'd1024 - {6'd0, dst_q[11:2]};
    beats_c  = rem_q;
    if (beats_c > MAX_B16)  beats_c = MAX_B16;
    if (room_src < beats_c) beats_c = room_src;
    if (room_dst < beats_c) beats_c = room_dst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = (words_i == 16'd0) ? S_DONE : S_CALC;
      S_CALC: state_d = S_AR;
      S_AR:   if (arready_i) state_d = S_R;
      S_R:    if (rvalid_i && rlast_i) state_d = S_AW;
      S_AW:   if (awready_i) state_d = S_W;
      S_W:    if (wready_i && wlast_o) state_d = S_B;
      S_B:    if (bvalid_i) state_d = (burst_last || err_q || berr) ? S_DONE : S_CALC;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid_o = 1'b0;
    araddr_o  = 32'h0;
    arlen_o   = 4'h0;
    rready_o  = 1'b0;
    awvalid_o = 1'b0;
    awaddr_o  = 32'h0;
    awlen_o   = 4'h0;
    wvalid_o  = 1'b0;
    wdata_o   = 32'h0;
    wlast_o   = 1'b0;
    bready_o  = 1'b0;
    case (state_q)
      S_AR: begin
        arvalid_o = 1'b1;
        araddr_o  = src_q;
        arlen_o   = len_m1[3:0];
      end
      S_R:  rready_o = 1'b1;
      S_AW: begin
        awvalid_o = 1'b1;
        awaddr_o  = dst_q;
        awlen_o   = len_m1[3:0];
      end
      S_W: begin
        wvalid_o = 1'b1;
        wdata_o  = buf_q[idx_q[3:0]];
        wlast_o  = last_rd;
      end
      S_B:  bready_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign arid_o    = AXI_ID;
  assign awid_o    = AXI_ID;
  assign arsize_o  = 3'b010;
  assign awsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign awburst_o = 2'b01;
  assign wstrb_o   = 4'hF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      rem_q   <= 16'h0;
      beats_q <= 5'd0;
      idx_q   <= 5'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (start_i) begin
          src_q <= {src_i[31:2], 2'b00};
          dst_q <= {dst_i[31:2], 2'b00};
          rem_q <= words_i;
          err_q <= 1'b0;
        end
        S_CALC: begin
          beats_q <= beats_c[4:0];
          idx_q   <= 5'd0;
        end
        // idx saturates so a late rlast cannot wrap it into valid buffer slots
        S_R: if (rvalid_i) begin
          if (idx_q < MAX_B5) idx_q <= idx_q + 5'd1;
          if (rresp_i != 2'b00 || rlast_i != last_rd) err_q <= 1'b1;
          if (rlast_i) idx_q <= 5'd0;
        end
        S_W: if (wready_i) idx_q <= idx_q + 5'd1;
        S_B: if (bvalid_i) begin
          if (berr) err_q <= 1'b1;
          src_q <= src_q + {25'd0, beats_q, 2'b00};
          dst_q <= dst_q + {25'd0, beats_q, 2'b00};
          rem_q <= rem_q - {11'd0, beats_q};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_R && rvalid_i && idx_q < MAX_B5)
      buf_q[idx_q[3:0]] <= rdata_i;
  end

`ifdef EPU_DMA_PERF_CNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cyc_q <= 32'h0;
    else if (state_q == S_IDLE && start_i)  cyc_q <= 32'h0;
    else if (busy_o)                        cyc_q <= cyc_q + 32'd1;
  end
  assign cycles_o = cyc_q;
`else
  assign cycles_o = 32'h0;
`endif

  logic unused_ok;
  assign unused_ok = ^{rid_i, bid_i, src_i[1:0], dst_i[1:0], beats_c[15:5]};

endmodule
